// File: rtl/clint_wires.sv
// clint_wires: shared CLINT constants, register-file struct and byte-lane merge helper.
package clint_wires;
    localparam int          clk_divider_rtc      = (1000000000 / 100000000) / 2 - 1;
    localparam logic [31:0] clint_base_addr      = 32'h0200_0000;
    localparam logic [31:0] clint_msip_off       = 32'h0000_0000;
    localparam logic [31:0] clint_mtimecmp_off   = 32'h0000_4000;
    localparam logic [31:0] clint_mtimecmp_hi_off = 32'h0000_4004;
    localparam logic [31:0] clint_mtime_off      = 32'h0000_BFF8;
    localparam logic [31:0] clint_mtime_hi_off   = 32'h0000_BFFC;

    typedef struct packed {
        logic [63:0] mtime;
        logic [63:0] mtimecmp;
        logic        msip;
        logic [31:0] rdata;
        logic        ready;
    } clint_reg_type;

    localparam clint_reg_type clint_reg_reset = '{
        mtime:    '0,
        mtimecmp: '1,
        msip:     1'b0,
        rdata:    '0,
        ready:    1'b0
    };

    function automatic logic [31:0] clint_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] m;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/clint_rtc_tick.sv
// clint_rtc_tick: divides clock into a half-period phase and pulses rtc_tick once per full RTC period.
module clint_rtc_tick #(
    parameter int rtc_divider = 4
) (
    input  logic clock,
    input  logic reset,
    output logic rtc_tick
);
    localparam int cw = rtc_divider > 0 ? $clog2(rtc_divider + 1) : 1;

    logic [cw-1:0] count;
    logic          phase, phase_d, wrap;

    assign wrap     = count == cw'(rtc_divider);
    assign rtc_tick = phase & ~phase_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            phase   <= 1'b0;
            phase_d <= 1'b0;
        end else begin
            count   <= wrap ? '0 : count + 1'b1;
            phase   <= phase ^ wrap;
            phase_d <= phase;
        end
    end
endmodule

// File: rtl/clint_timer.sv
// clint_timer: CLINT with mtime/mtimecmp/msip registers driving mtip and msip.
// Define CLINT_MTIME_WRITE_EN to make mtime writable from the bus.
module clint_timer
    import clint_wires::*;
#(
    parameter int          rtc_divider = clk_divider_rtc,
    parameter logic [31:0] base_addr   = clint_base_addr
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime_out
);
    clint_reg_type r, v;
    logic          rtc_tick, wr, mtime_lo_wr, mtime_hi_wr, unused;
    logic [31:0]   off, rd;

    clint_rtc_tick #(.rtc_divider(rtc_divider)) u_rtc_tick (
        .clock   (clock),
        .reset   (reset),
        .rtc_tick(rtc_tick)
    );

    assign unused = mem_instr;
    assign off    = (mem_addr - base_addr) & ~32'h3;
    assign wr     = mem_valid & (|mem_wstrb);

`ifdef CLINT_MTIME_WRITE_EN
    assign mtime_lo_wr = wr & (off == clint_mtime_off);
    assign mtime_hi_wr = wr & (off == clint_mtime_hi_off);
`else
    assign mtime_lo_wr = 1'b0;
    assign mtime_hi_wr = 1'b0;
`endif

    assign rd = off == clint_msip_off        ? {31'b0, r.msip}     :
                off == clint_mtimecmp_off    ? r.mtimecmp[31:0]    :
                off == clint_mtimecmp_hi_off ? r.mtimecmp[63:32]   :
                off == clint_mtime_off       ? r.mtime[31:0]       :
                off == clint_mtime_hi_off    ? r.mtime[63:32]      : 32'h0;

    always_comb begin
        v                 = r;
        v.ready           = mem_valid;
        v.rdata           = mem_valid ? rd : r.rdata;
        v.msip            = (wr && off == clint_msip_off && mem_wstrb[0]) ? mem_wdata[0] : r.msip;
        v.mtimecmp[31:0]  = (wr && off == clint_mtimecmp_off) ?
                            clint_merge(r.mtimecmp[31:0], mem_wdata, mem_wstrb) : r.mtimecmp[31:0];
        v.mtimecmp[63:32] = (wr && off == clint_mtimecmp_hi_off) ?
                            clint_merge(r.mtimecmp[63:32], mem_wdata, mem_wstrb) : r.mtimecmp[63:32];
        // a bus write to either mtime half swallows a coincident tick
        v.mtime           = (rtc_tick && !mtime_lo_wr && !mtime_hi_wr) ? r.mtime + 64'd1 : r.mtime;
        v.mtime[31:0]     = mtime_lo_wr ? clint_merge(r.mtime[31:0], mem_wdata, mem_wstrb) : v.mtime[31:0];
        v.mtime[63:32]    = mtime_hi_wr ? clint_merge(r.mtime[63:32], mem_wdata, mem_wstrb) : v.mtime[63:32];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r    <= clint_reg_reset;
            mtip <= 1'b0;
            msip <= 1'b0;
        end else begin
            r    <= v;
            mtip <= r.mtime >= r.mtimecmp;
            msip <= r.msip;
        end
    end

    assign mem_rdata = r.rdata;
    assign mem_ready = r.ready;
    assign mtime_out = r.mtime;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed plan plus randomized traffic against a cycle-level model of the CLINT.
module tb_clint_timer;
    localparam int          div    = 4;
    localparam int          period = 2 * (div + 1);
    localparam logic [31:0] base   = 32'h0200_0000;
`ifdef CLINT_MTIME_WRITE_EN
    localparam bit mtime_wen = 1'b1;
`else
    localparam bit mtime_wen = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, mem_instr, mem_ready, mtip, msip;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [63:0] mtime_out;

    clint_timer #(.rtc_divider(div), .base_addr(base)) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mtip     (mtip),
        .msip     (msip),
        .mtime_out(mtime_out)
    );

    always #5 clock = ~clock;

    int          checks, failures, t;
    logic [63:0] m_time, m_cmp, old;
    logic        m_msip, m_msip_o, m_mtip, m_ready;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] reg_read(input logic [31:0] a);
        case ((a - base) & ~32'h3)
            32'h0000: return {31'b0, m_msip};
            32'h4000: return m_cmp[31:0];
            32'h4004: return m_cmp[63:32];
            32'hBFF8: return m_time[31:0];
            32'hBFFC: return m_time[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic compare_all();
        check("ready", mem_ready, m_ready);
        check("rdata", mem_rdata, m_rdata);
        check("mtip",  mtip,      m_mtip);
        check("msip",  msip,      m_msip_o);
        check("mtime", mtime_out, m_time);
    endtask

    task automatic do_reset(input logic v);
        mem_valid = v;
        mem_addr  = base + 32'hBFF8;
        mem_wstrb = 4'h0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mem_valid = 1'b0;
        m_time = '0; m_cmp = '1; m_msip = 0; m_msip_o = 0; m_mtip = 0; m_ready = 0; m_rdata = '0; t = 0;
        compare_all();
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        logic        wr, lo_w, hi_w, nm;
        logic [63:0] nt, nc;
        mem_valid = v; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = 1'($urandom);
        off  = (a - base) & ~32'h3;
        wr   = v && s != 4'h0;
        lo_w = wr && mtime_wen && off == 32'hBFF8;
        hi_w = wr && mtime_wen && off == 32'hBFFC;
        nt   = (t % period == div + 1 && !lo_w && !hi_w) ? m_time + 64'd1 : m_time;
        if (lo_w) nt[31:0]  = lanes(m_time[31:0], d, s);
        if (hi_w) nt[63:32] = lanes(m_time[63:32], d, s);
        nc = m_cmp;
        if (wr && off == 32'h4000) nc[31:0]  = lanes(m_cmp[31:0], d, s);
        if (wr && off == 32'h4004) nc[63:32] = lanes(m_cmp[63:32], d, s);
        nm       = (wr && off == 32'h0 && s[0]) ? d[0] : m_msip;
        m_mtip   = m_time >= m_cmp;
        m_msip_o = m_msip;
        m_ready  = v;
        if (v) m_rdata = reg_read(a);
        @(posedge clock);
        #1;
        m_time = nt; m_cmp = nc; m_msip = nm; t++;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, base, 32'h0, 4'h0);
    endtask

    initial begin
        logic [31:0] a;
        checks = 0; failures = 0; t = 0;
        mem_valid = 0; mem_instr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        do_reset(1'b1);
        repeat (100) idle();
        check("mtime_after_100", mtime_out, 64'd10);

        step(1'b1, base, 32'h1, 4'hF);
        check("msip_wr_ack", mem_ready, 1'b1);
        idle();
        check("msip_set", msip, 1'b1);
        step(1'b1, base, 32'h0, 4'hF);
        idle();
        check("msip_clear", msip, 1'b0);

        do_reset(1'b0);
        step(1'b1, base + 32'h4004, 32'h0, 4'hF);
        step(1'b1, base + 32'h4000, 32'h5, 4'hF);
        for (int i = 0; i < 200 && !mtip; i++) idle();
        check("mtip_rise", mtip, 1'b1);
        check("mtip_rise_mtime", mtime_out, 64'd5);
        for (int i = 0; i < 100 && mtime_out != 64'd7; i++) idle();
        step(1'b1, base + 32'hBFF8, 32'h0, 4'h0);
        check("read_mtime_lo", mem_rdata, 32'h7);
        step(1'b1, base + 32'h4004, 32'hFFFF_FFFF, 4'hF);
        step(1'b1, base + 32'h4000, 32'h0, 4'hF);
        idle();
        check("mtip_fall", mtip, 1'b0);
        step(1'b1, base + 32'h100, $urandom, 4'h0);
        check("unmapped_ready", mem_ready, 1'b1);
        check("unmapped_rdata", mem_rdata, 32'h0);

        do_reset(1'b0);
        step(1'b1, base + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        check("mtime_wr_ack", mem_ready, 1'b1);
        step(1'b1, base + 32'hBFFC, 32'h0, 4'hF);
        repeat (period) idle();
        step(1'b1, base + 32'hBFFC, 32'h0, 4'h0);
        check("mtime_hi_after_tick", mem_rdata, mtime_wen ? 32'h1 : 32'h0);
        step(1'b1, base + 32'hBFF8, 32'h0, 4'h0);
        check("mtime_lo_after_tick", mem_rdata, mtime_wen ? 32'h0 : 32'h1);
        for (int i = 0; i < period && t % period != div + 1; i++) idle();
        old = mtime_out;
        step(1'b1, base + 32'hBFF8, 32'h1234, 4'hF);
        check("mtime_wr_vs_tick", mtime_out, mtime_wen ? {old[63:32], 32'h1234} : old + 64'd1);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1'($urandom));
            else begin
                case ($urandom_range(0, 6))
                    0:       a = base;
                    1:       a = base + 32'h4000;
                    2:       a = base + 32'h4004;
                    3:       a = base + 32'hBFF8;
                    4:       a = base + 32'hBFFC;
                    5:       a = base + 32'h100;
                    default: a = base + ($urandom & 32'hFFFC);
                endcase
                a = a | 32'($urandom_range(0, 3));
                step($urandom_range(0, 3) != 0, a,
                     $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 64)) : $urandom,
                     $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
